// File: rtl/layer_ctrl_pkg.sv
// Shared types and constants for the layer priority controller.
// Build option LAYER_COLOR_KEY_EN (used by layer_priority_ctrl) makes COLOR_KEY pixels transparent.
package layer_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   localparam logic [1:0] FLD_ENABLE = 2'd0;
   localparam logic [1:0] FLD_RANK   = 2'd1;
   localparam logic [1:0] FLD_BLINK  = 2'd2;
   localparam logic [1:0] FLD_RSVD   = 2'd3;

   localparam logic [7:0] COLOR_KEY = 8'hFF;

   // Storage width of a rank; the controller's RANK_W must not exceed it.
   localparam int CFG_RANK_W = 3;

   typedef struct packed {
      logic                  enable;
      logic [CFG_RANK_W-1:0] rank;
      logic [2:0]            blink_sel;
   } layer_cfg_t;

   // Power-up settings: everything enabled, rank equals layer index, no blinking.
   function automatic layer_cfg_t default_cfg(input int idx);
      layer_cfg_t c;
      c.enable    = 1'b1;
      c.rank      = CFG_RANK_W'(idx);
      c.blink_sel = 3'd0;
      return c;
   endfunction

endpackage

// File: rtl/layer_prio_select.sv
// Combinational winner finder: lowest rank among eligible layers, lowest index on ties.
module layer_prio_select #(
   parameter int NUM_LAYERS = 8,
   parameter int RANK_W     = 3,
   parameter int LAYER_W    = 3
) (
   input  logic [NUM_LAYERS-1:0]             eligible,
   input  logic [NUM_LAYERS-1:0][RANK_W-1:0] rank,
   output logic [LAYER_W-1:0]                win,
   output logic                              any_eligible
);

   logic [RANK_W-1:0] best_rank;

   // Ascending scan with a strict compare keeps the lower index on equal ranks.
   always_comb begin
      win          = '0;
      any_eligible = 1'b0;
      best_rank    = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (eligible[i] && (!any_eligible || (rank[i] < best_rank))) begin
            any_eligible = 1'b1;
            best_rank    = rank[i];
            win          = LAYER_W'(i);
         end
      end
   end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Run-time configurable layer compositor with frame-atomic settings commit.
// Build option LAYER_COLOR_KEY_EN: a layer drawing 8'hFF is treated as transparent.
module layer_priority_ctrl
   import layer_ctrl_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int RANK_W     = 3,
   parameter int LAYER_W    = 3
) (
   input  logic                            clk,
   input  logic                            resetN,
   input  logic                            startOfFrame,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [LAYER_W-1:0]              cfg_layer,
   input  logic [1:0]                      cfg_field,
   input  logic [7:0]                      cfg_data,
   input  logic [NUM_LAYERS-1:0]           layerDR,
   input  logic [NUM_LAYERS-1:0][7:0]      layerRGB,
   input  logic [7:0]                      backGroundRGB,
   output logic [7:0]                      RGBOut,
   output logic [LAYER_W-1:0]              selLayer,
   output logic                            selValid,
   output logic [7:0]                      frameCnt
);

   state_t state_reg, state_next;

   logic [7:0]         frame_cnt_reg;
   logic [7:0]         rgb_reg;
   logic [LAYER_W-1:0] sel_layer_reg;
   logic               sel_valid_reg;

   logic cfg_accept;
   logic cfg_effective;
   logic layer_in_range;
   logic cfg_data_unused;

   logic [NUM_LAYERS-1:0]             eligible;
   logic [NUM_LAYERS-1:0]             visible;
   logic [NUM_LAYERS-1:0]             keyed;
   logic [NUM_LAYERS-1:0]             act_enable;
   logic [NUM_LAYERS-1:0][RANK_W-1:0] act_rank;
   logic [LAYER_W-1:0]                win;
   logic                              any_win;

   assign cfg_ready       = (state_reg != COMMIT);
   assign cfg_accept      = cfg_valid && cfg_ready;
   assign layer_in_range  = (32'(cfg_layer) < NUM_LAYERS);
   // Reserved-field and out-of-range writes are swallowed without dirtying the shadow.
   assign cfg_effective   = cfg_accept && layer_in_range && (cfg_field != FLD_RSVD);
   assign cfg_data_unused = ^cfg_data[7:3];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cfg_effective) state_next = PENDING;
         PENDING: if (startOfFrame)  state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      layer_cfg_t shadow_reg;
      layer_cfg_t active_reg;
      logic       wr_hit;

      assign wr_hit = cfg_effective && (cfg_layer == LAYER_W'(gi));

      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            shadow_reg <= default_cfg(gi);
            active_reg <= default_cfg(gi);
         end else begin
            if (wr_hit) begin
               case (cfg_field)
                  FLD_ENABLE: shadow_reg.enable    <= cfg_data[0];
                  FLD_RANK:   shadow_reg.rank      <= CFG_RANK_W'(cfg_data[RANK_W-1:0]);
                  FLD_BLINK:  shadow_reg.blink_sel <= cfg_data[2:0];
                  default:    ;
               endcase
            end
            if (state_reg == COMMIT) active_reg <= shadow_reg;
         end
      end

      assign act_enable[gi] = active_reg.enable;
      assign act_rank[gi]   = RANK_W'(active_reg.rank);
      // blink_sel=k shows the layer while bit k-1 of the frame counter is clear.
      assign visible[gi]    = (active_reg.blink_sel == 3'd0) ||
                              !frame_cnt_reg[active_reg.blink_sel - 3'd1];
`ifdef LAYER_COLOR_KEY_EN
      assign keyed[gi]      = (layerRGB[gi] == COLOR_KEY);
`else
      assign keyed[gi]      = 1'b0;
`endif
      assign eligible[gi]   = layerDR[gi] && act_enable[gi] && visible[gi] && !keyed[gi];
   end

   layer_prio_select #(
      .NUM_LAYERS (NUM_LAYERS),
      .RANK_W     (RANK_W),
      .LAYER_W    (LAYER_W)
   ) u_select (
      .eligible     (eligible),
      .rank         (act_rank),
      .win          (win),
      .any_eligible (any_win)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rgb_reg       <= 8'd0;
         sel_layer_reg <= '0;
         sel_valid_reg <= 1'b0;
         frame_cnt_reg <= 8'd0;
      end else begin
         rgb_reg       <= any_win ? layerRGB[win] : backGroundRGB;
         sel_layer_reg <= any_win ? win : '0;
         sel_valid_reg <= any_win;
         if (startOfFrame) frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
   end

   assign RGBOut   = rgb_reg;
   assign selLayer = sel_layer_reg;
   assign selValid = sel_valid_reg;
   assign frameCnt = frame_cnt_reg;

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Self-checking bench for layer_priority_ctrl against a behavioural compositor model.
module tb_layer_priority_ctrl;

   localparam int N = 8;

   logic            clk = 1'b0;
   logic            resetN = 1'b0;
   logic            startOfFrame = 1'b0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [2:0]      cfg_layer = 3'd0;
   logic [1:0]      cfg_field = 2'd0;
   logic [7:0]      cfg_data = 8'd0;
   logic [7:0]      layerDR = 8'd0;
   logic [7:0][7:0] layerRGB = '0;
   logic [7:0]      backGroundRGB = 8'd0;
   logic [7:0]      RGBOut;
   logic [2:0]      selLayer;
   logic            selValid;
   logic [7:0]      frameCnt;

   layer_priority_ctrl #(.NUM_LAYERS(8), .RANK_W(3), .LAYER_W(3)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_layer     (cfg_layer),
      .cfg_field     (cfg_field),
      .cfg_data      (cfg_data),
      .layerDR       (layerDR),
      .layerRGB      (layerRGB),
      .backGroundRGB (backGroundRGB),
      .RGBOut        (RGBOut),
      .selLayer      (selLayer),
      .selValid      (selValid),
      .frameCnt      (frameCnt)
   );

   always #5 clk = ~clk;

   // Model: settings the next frame will get, settings on screen now, and commit bookkeeping.
   bit   sh_en[N], ac_en[N];
   int   sh_rank[N], ac_rank[N], sh_blink[N], ac_blink[N];
   bit   m_dirty, m_committing;
   int   m_frame;
   logic [7:0] exp_rgb;
   logic [2:0] exp_sel;
   logic       exp_valid;
   int   checks = 0;
   int   failures = 0;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         sh_en[i] = 1'b1; ac_en[i] = 1'b1;
         sh_rank[i] = i;  ac_rank[i] = i;
         sh_blink[i] = 0; ac_blink[i] = 0;
      end
      m_dirty = 1'b0; m_committing = 1'b0; m_frame = 0;
      exp_rgb = 8'd0; exp_sel = 3'd0; exp_valid = 1'b0;
   endfunction

   // One pixel clock: predict the registered result, advance model and DUT together.
   task automatic step();
      int  best_key;
      int  win;
      bit  ok, acc, eff;
      best_key = -1;
      win = 0;
      for (int i = 0; i < N; i++) begin
         ok = layerDR[i] && ac_en[i] &&
              (ac_blink[i] == 0 || ((m_frame >> (ac_blink[i] - 1)) % 2) == 0);
`ifdef LAYER_COLOR_KEY_EN
         if (layerRGB[i] == 8'hFF) ok = 1'b0;
`endif
         if (ok && (best_key < 0 || ac_rank[i] * N + i < best_key)) begin
            best_key = ac_rank[i] * N + i;
            win = i;
         end
      end
      exp_valid = (best_key >= 0);
      exp_sel   = exp_valid ? 3'(win) : 3'd0;
      exp_rgb   = exp_valid ? layerRGB[win] : backGroundRGB;

      acc = cfg_valid && !m_committing;
      eff = acc && (cfg_field != 2'd3);
      if (m_committing) begin
         ac_en = sh_en; ac_rank = sh_rank; ac_blink = sh_blink;
      end
      if (eff) begin
         case (cfg_field)
            2'd0:    sh_en[cfg_layer]    = cfg_data[0];
            2'd1:    sh_rank[cfg_layer]  = int'(cfg_data[2:0]);
            default: sh_blink[cfg_layer] = int'(cfg_data[2:0]);
         endcase
      end
      if (acc)
         $display("cfg write layer=%0d field=%0d data=%02h sof=%0d", cfg_layer, cfg_field, cfg_data, startOfFrame);
      if (m_committing)                 m_committing = 1'b0;
      else if (m_dirty && startOfFrame) begin m_dirty = 1'b0; m_committing = 1'b1; end
      else if (eff)                     m_dirty = 1'b1;
      if (startOfFrame) m_frame = (m_frame + 1) % 256;

      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic set_cfg(input int layer, input int field, input int data);
      cfg_valid = 1'b1;
      cfg_layer = 3'(layer);
      cfg_field = 2'(field);
      cfg_data  = 8'(data);
   endtask

   task automatic assert_reset();
      #1;
      resetN = 1'b0;
      model_reset();
      #2;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      #6;
      model_reset();
      checks++;
      if ({RGBOut, selLayer, selValid, frameCnt, cfg_ready} !== {8'd0, 3'd0, 1'b0, 8'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got rgb=%02h sel=%0d valid=%0b frame=%0d ready=%0b want 00/0/0/0/1",
                  RGBOut, selLayer, selValid, frameCnt, cfg_ready);
      end
      release_reset();
      layerDR = 8'b0000_0110;
      layerRGB[1] = 8'h1C;
      layerRGB[2] = 8'hE0;
      backGroundRGB = 8'h33;
      step();
      checks++;
      if ({RGBOut, selLayer, selValid} !== {8'h1C, 3'd1, 1'b1}) begin
         failures++;
         $display("FAIL reset_default_select got rgb=%02h sel=%0d valid=%0b want 1c/1/1", RGBOut, selLayer, selValid);
      end
   endtask

   task automatic test_rank_commit();
      set_cfg(2, 1, 0);
      step();
      set_cfg(1, 1, 5);
      step();
      step();
      checks++;
      if (RGBOut !== 8'h1C || RGBOut !== exp_rgb) begin
         failures++;
         $display("FAIL rank_not_yet_committed got rgb=%02h want 1c", RGBOut);
      end
      startOfFrame = 1'b1;
      step();
      checks++;
      if (cfg_ready !== 1'b0 || RGBOut !== 8'h1C) begin
         failures++;
         $display("FAIL commit_cycle got ready=%0b rgb=%02h want ready=0 rgb=1c", cfg_ready, RGBOut);
      end
      step();
      checks++;
      if (cfg_ready !== 1'b1 || RGBOut !== 8'h1C || RGBOut !== exp_rgb) begin
         failures++;
         $display("FAIL after_commit_old_pixel got ready=%0b rgb=%02h want ready=1 rgb=1c", cfg_ready, RGBOut);
      end
      step();
      checks++;
      if ({RGBOut, selLayer, selValid} !== {8'hE0, 3'd2, 1'b1}) begin
         failures++;
         $display("FAIL rank_committed got rgb=%02h sel=%0d want e0/2", RGBOut, selLayer);
      end
   endtask

   task automatic test_enable_same_frame();
      int bad = 0;
      set_cfg(7, 2, 0);
      step();
      set_cfg(1, 0, 0);
      startOfFrame = 1'b1;
      step();
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL enable_sof_commit got ready=%0b want 0", cfg_ready);
      end
      step();
      for (int k = 0; k < 40; k++) begin
         layerDR = 8'($urandom_range(0, 255)) | 8'h02;
         if (k % 5 == 0) layerDR = 8'b1100_0010;
         for (int i = 0; i < N; i++) layerRGB[i] = 8'($urandom_range(0, 254));
         step();
         checks++;
         if ({RGBOut, selLayer, selValid} !== {exp_rgb, exp_sel, exp_valid} || selLayer === 3'd1) begin
            failures++; bad++;
            $display("FAIL enable_off_pixel got rgb=%02h sel=%0d valid=%0b want %02h/%0d/%0b",
                     RGBOut, selLayer, selValid, exp_rgb, exp_sel, exp_valid);
         end
      end
   endtask

   task automatic test_blink_and_wrap();
      assert_reset();
      release_reset();
      layerDR = 8'h01;
      layerRGB[0] = 8'h4B;
      set_cfg(0, 2, 1);
      step();
      startOfFrame = 1'b1;
      step();
      step();
      for (int f = 0; f < 8; f++) begin
         startOfFrame = 1'b1;
         step();
         step();
         checks++;
         if ({RGBOut, selValid, frameCnt} !== {exp_rgb, exp_valid, 8'(m_frame)} || exp_valid !== (m_frame % 2 == 0)) begin
            failures++;
            $display("FAIL blink_frame got valid=%0b frame=%0d want valid=%0b frame=%0d",
                     selValid, frameCnt, exp_valid, m_frame);
         end
      end
      while (m_frame != 255) begin
         startOfFrame = 1'b1;
         step();
      end
      checks++;
      if (frameCnt !== 8'd255) begin
         failures++;
         $display("FAIL frame_before_wrap got %0d want 255", frameCnt);
      end
      startOfFrame = 1'b1;
      step();
      checks++;
      if (frameCnt !== 8'd0) begin
         failures++;
         $display("FAIL frame_wrap got %0d want 0", frameCnt);
      end
   endtask

   task automatic test_ties_and_background();
      assert_reset();
      release_reset();
      set_cfg(3, 1, 0);
      step();
      set_cfg(5, 1, 0);
      step();
      startOfFrame = 1'b1;
      step();
      step();
      layerDR = 8'b0010_1000;
      layerRGB[3] = 8'h03;
      layerRGB[5] = 8'h05;
      step();
      checks++;
      if ({RGBOut, selLayer, selValid} !== {8'h03, 3'd3, 1'b1}) begin
         failures++;
         $display("FAIL tie_lower_index got rgb=%02h sel=%0d want 03/3", RGBOut, selLayer);
      end
      layerDR = 8'd0;
      backGroundRGB = 8'h5A;
      step();
      checks++;
      if ({RGBOut, selLayer, selValid} !== {8'h5A, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL background got rgb=%02h sel=%0d valid=%0b want 5a/0/0", RGBOut, selLayer, selValid);
      end
   endtask

   task automatic test_reset_mid_pending();
      set_cfg(7, 1, 0);
      step();
      set_cfg(0, 0, 0);
      step();
      assert_reset();
      checks++;
      if ({RGBOut, selValid, cfg_ready} !== {8'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid_pending got rgb=%02h valid=%0b ready=%0b want 00/0/1", RGBOut, selValid, cfg_ready);
      end
      release_reset();
      startOfFrame = 1'b1;
      step();
      step();
      layerDR = 8'h81;
      layerRGB[0] = 8'h11;
      layerRGB[7] = 8'h77;
      step();
      checks++;
      if ({RGBOut, selLayer, selValid} !== {8'h11, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL pending_discarded got rgb=%02h sel=%0d want 11/0", RGBOut, selLayer);
      end
   endtask

   task automatic test_color_key();
      layerDR = 8'h03;
      layerRGB[0] = 8'hFF;
      layerRGB[1] = 8'h42;
      step();
      checks++;
`ifdef LAYER_COLOR_KEY_EN
      if ({RGBOut, selLayer, selValid} !== {8'h42, 3'd1, 1'b1}) begin
         failures++;
         $display("FAIL color_key got rgb=%02h sel=%0d want 42/1", RGBOut, selLayer);
      end
`else
      if ({RGBOut, selLayer, selValid} !== {8'hFF, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL color_key_off got rgb=%02h sel=%0d want ff/0", RGBOut, selLayer);
      end
`endif
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) < 3) set_cfg($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
         startOfFrame = ($urandom_range(0, 9) == 0);
         layerDR = 8'($urandom_range(0, 255));
         for (int i = 0; i < N; i++)
            layerRGB[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         backGroundRGB = 8'($urandom_range(0, 255));
         step();
         checks++;
         if ({RGBOut, selLayer, selValid, frameCnt, cfg_ready} !==
             {exp_rgb, exp_sel, exp_valid, 8'(m_frame), !m_committing}) begin
            failures++;
            $display("FAIL random_pixel got rgb=%02h sel=%0d valid=%0b frame=%0d ready=%0b want %02h/%0d/%0b/%0d/%0b",
                     RGBOut, selLayer, selValid, frameCnt, cfg_ready,
                     exp_rgb, exp_sel, exp_valid, m_frame, !m_committing);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rank_commit();
      test_enable_same_frame();
      test_blink_and_wrap();
      test_ties_and_background();
      test_reset_mid_pending();
      test_color_key();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_priority_ctrl.md
Name: layer_priority_ctrl

Overview:
- Run-time configurable layer compositor and controller that replaces fixed-priority object selection.
- Holds per-layer enable, priority rank and blink settings in shadow registers, written through a valid/ready config port.
- Commits settings atomically on start-of-frame so a frame never tears.
- Selects the winning layer per pixel and registers its RGB; sits between the object drawers and the VGA output stage.

Parameters:
- NUM_LAYERS, 8, number of drawing layers (max 8).
- RANK_W, 3, width of a priority rank; lower value = higher priority.
- LAYER_W, 3, width of a layer index (clog2 NUM_LAYERS).

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at first pixel of a frame.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid&&ready.
- cfg_layer  in  LAYER_W  target layer index.
- cfg_field  in  2  0=enable, 1=rank, 2=blink_sel, 3=reserved.
- cfg_data  in  8  write data.
- layerDR  in  NUM_LAYERS  per-layer drawing request.
- layerRGB  in  NUM_LAYERS x 8  per-layer pixel colour.
- backGroundRGB  in  8  colour used when no layer wins.
- RGBOut  out  8  registered output pixel.
- selLayer  out  LAYER_W  registered index of winning layer.
- selValid  out  1  registered; 1 if a layer won, 0 if background.
- frameCnt  out  8  free-running frame counter.

Behaviour:
- Reset (async, resetN low): RGBOut=0, selLayer=0, selValid=0, frameCnt=0, state=IDLE. Shadow and active: enable=1, rank[i]=i, blink_sel=0. Pending writes are discarded.
- State machine:
  - IDLE: no pending change. An accepted write goes to PENDING.
  - PENDING: shadow is dirty. startOfFrame goes to COMMIT.
  - COMMIT: one cycle; copies shadow to active, then returns to IDLE.
- cfg_ready = (state != COMMIT).
- Config writes:
  - Field 0 writes cfg_data[0]. Field 1 writes cfg_data[RANK_W-1:0]. Field 2 writes cfg_data[2:0].
  - Field 3 is accepted with no effect and does not set dirty.
  - cfg_layer >= NUM_LAYERS: accepted and ignored.
- Write and startOfFrame in the same cycle while PENDING: the write lands in shadow and is included in the COMMIT.
- Write and startOfFrame in the same cycle while IDLE: state goes to PENDING, and the write commits at the next frame.
- frameCnt: increments on startOfFrame, wraps 255->0.
- Eligibility: layer i is eligible when layerDR[i] && enable[i] && visible[i].
  - visible = 1 if blink_sel==0, else frameCnt[blink_sel-1]==0.
  - blink_sel=1 toggles every frame; 7 toggles every 64 frames.
- Selection:
  - Among eligible layers, the minimum active rank wins; on equal ranks, the lower index wins.
  - Result is registered next cycle: RGBOut=layerRGB[win], selLayer=win, selValid=1.
  - With no eligible layer: RGBOut=backGroundRGB, selLayer=0, selValid=0.
- Latency: 1 clock from inputs to RGBOut for every pixel.
- Timing of committed settings: active values are used from the cycle after COMMIT. Pixels in the COMMIT cycle still use the old settings.

Optional Feature:
- Macro LAYER_COLOR_KEY_EN.
  - Defined: a layer whose layerRGB equals 8'hFF is treated as not drawing, so lower-priority layers show through.
  - Undefined: 8'hFF is an ordinary colour and only layerDR gates eligibility.

Decomposition:
- Package layer_ctrl_pkg holds:
  - state enum {IDLE, PENDING, COMMIT};
  - field codes FLD_ENABLE=0, FLD_RANK=1, FLD_BLINK=2, FLD_RSVD=3;
  - COLOR_KEY=8'hFF;
  - a layer_cfg_t struct {enable, rank, blink_sel}.
- Sub-module layer_prio_select: purely combinational min-rank/lowest-index finder. Outputs win index and any-eligible flag.

Test Plan:
- Reset defaults: layerDR=8'b0000_0110, layerRGB[1]=8'h1C, layerRGB[2]=8'hE0 -> next cycle RGBOut=8'h1C, selLayer=1, selValid=1.
- Write rank layer2=0, rank layer1=5 with no startOfFrame -> output stays 8'h1C. After startOfFrame plus COMMIT -> RGBOut=8'hE0, selLayer=2; cfg_ready=0 exactly during the COMMIT cycle.
- Enable layer1=0 with startOfFrame in the same cycle while PENDING -> included in the commit; layer1 never selected afterwards.
- blink_sel layer0=1, layerDR=8'h01 -> selValid alternates 1,0,1,... on successive frames (frameCnt even = visible). frameCnt wraps 255->0.
- Ties: ranks of layer3 and layer5 both 0, both drawing -> selLayer=3. No drawing -> RGBOut=backGroundRGB, selValid=0.
- Reset asserted mid-PENDING -> state IDLE, settings back to defaults. With LAYER_COLOR_KEY_EN defined: layerRGB[0]=8'hFF on top -> the next layer's colour is output.
